// File: rtl/cotm32_priv_pkg.sv
// Machine-mode privileged definitions shared by the trap path:
// exception/interrupt cause codes, trap FSM states and the mcause builder.
package cotm32_priv_pkg;

    localparam int XLEN  = 32;
    localparam int MXLEN = 32;

    typedef enum logic [4:0] {
        TRAP_INST_ADDR_MISALIGNED  = 5'd0,
        TRAP_ILLEGAL_INST          = 5'd2,
        TRAP_BREAKPOINT            = 5'd3,
        TRAP_LOAD_ADDR_MISALIGNED  = 5'd4,
        TRAP_STORE_ADDR_MISALIGNED = 5'd6,
        TRAP_ECALL_M               = 5'd11
    } trap_cause_t;

    typedef enum logic [4:0] {
        IRQ_M_SOFT    = 5'd3,
        IRQ_M_TIMER   = 5'd7,
        IRQ_M_EXT     = 5'd11,
        IRQ_PLAT_BASE = 5'd16
    } irq_cause_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } trap_state_t;

    function automatic logic [MXLEN-1:0] mk_mcause(input logic is_irq, input logic [4:0] code);
        mk_mcause = {is_irq, {(MXLEN-6){1'b0}}, code};
    endfunction

endpackage

// File: rtl/trap_irq_sync.sv
// Multi-flop synchroniser for asynchronous level interrupt lines; all stages
// clear to 0 on reset.
module trap_irq_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_async;
            for (int s = 1; s < STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Registered trap controller: merges execute-stage exceptions with synchronised
// machine interrupts into one prioritised request held until the CSR unit acks.
module trap_ctrl
    import cotm32_priv_pkg::*;
#(
    parameter int N_PLAT_IRQ      = 4,
    parameter int IRQ_SYNC_STAGES = 2,
    localparam int PW             = (N_PLAT_IRQ > 0) ? N_PLAT_IRQ : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inst_valid,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_inst,
    input  logic [XLEN-1:0]  i_ls_addr,
    input  logic             i_illegal_inst,
    input  logic             i_inst_addr_misaligned,
    input  logic             i_ecall_m,
    input  logic             i_ebreak,
    input  logic             i_load_addr_misaligned,
    input  logic             i_store_addr_misaligned,
    input  logic             i_irq_msi,
    input  logic             i_irq_mti,
    input  logic             i_irq_mei,
    input  logic [PW-1:0]    i_irq_plat,
    input  logic             i_mstatus_mie,
    input  logic [MXLEN-1:0] i_mie,
    output logic [MXLEN-1:0] o_mip,
    output logic             o_trap_valid,
    input  logic             i_trap_ack,
    output logic [MXLEN-1:0] o_mcause,
    output logic [MXLEN-1:0] o_mtval,
    output logic [XLEN-1:0]  o_mepc,
    output logic             o_stall
);

    localparam int W = 3 + N_PLAT_IRQ;

    trap_state_t      r_state;
    trap_state_t      w_state_next;
    logic [MXLEN-1:0] r_mcause;
    logic [MXLEN-1:0] r_mtval;
    logic [XLEN-1:0]  r_mepc;

    logic [W-1:0]     w_irq_raw;
    logic [W-1:0]     w_irq_sync;
    logic [MXLEN-1:0] w_mip;
    logic [MXLEN-1:0] w_pend;
    logic [4:0]       w_irq_code;
    logic             w_irq_take;
    logic             w_exc;
    trap_cause_t      w_exc_code;
    logic [MXLEN-1:0] w_exc_tval;
    logic             w_capture;

    // Packed order: bit0 MSI, bit1 MTI, bit2 MEI, bit 3+i platform line i.
    generate
        if (N_PLAT_IRQ > 0) begin : g_plat
            assign w_irq_raw = {i_irq_plat, i_irq_mei, i_irq_mti, i_irq_msi};
        end else begin : g_no_plat
            logic w_unused_plat;
            assign w_irq_raw     = {i_irq_mei, i_irq_mti, i_irq_msi};
            assign w_unused_plat = ^i_irq_plat;
        end
    endgenerate

    trap_irq_sync #(
        .WIDTH  (W),
        .STAGES (IRQ_SYNC_STAGES)
    ) u_irq_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (w_irq_raw),
        .o_sync  (w_irq_sync)
    );

    generate
        for (genvar b = 0; b < MXLEN; b++) begin : g_mip
            if (b == 3) begin : g_msi
                assign w_mip[b] = w_irq_sync[0];
            end else if (b == 7) begin : g_mti
                assign w_mip[b] = w_irq_sync[1];
            end else if (b == 11) begin : g_mei
                assign w_mip[b] = w_irq_sync[2];
            end else if (b >= 16 && b < 16 + N_PLAT_IRQ) begin : g_pl
                assign w_mip[b] = w_irq_sync[b-13];
            end else begin : g_zero
                assign w_mip[b] = 1'b0;
            end
        end
    endgenerate

    assign w_pend = w_mip & i_mie;

    // Lowest priority is assigned first so each later hit overrides it.
    always_comb begin
        w_irq_code = 5'd0;
        for (int i = N_PLAT_IRQ - 1; i >= 0; i--) begin
            if (w_pend[16+i]) w_irq_code = 5'(16 + i);
        end
        if (w_pend[7])  w_irq_code = IRQ_M_TIMER;
        if (w_pend[3])  w_irq_code = IRQ_M_SOFT;
        if (w_pend[11]) w_irq_code = IRQ_M_EXT;
        w_irq_take = i_mstatus_mie & (|w_pend);
    end

    always_comb begin
        w_exc      = 1'b1;
        w_exc_code = TRAP_ILLEGAL_INST;
        w_exc_tval = '0;
        if (i_illegal_inst) begin
            w_exc_tval = i_inst;
        end else if (i_inst_addr_misaligned) begin
            w_exc_code = TRAP_INST_ADDR_MISALIGNED;
            w_exc_tval = i_pc;
        end else if (i_ecall_m) begin
            w_exc_code = TRAP_ECALL_M;
        end else if (i_ebreak) begin
            w_exc_code = TRAP_BREAKPOINT;
        end else if (i_load_addr_misaligned) begin
            w_exc_code = TRAP_LOAD_ADDR_MISALIGNED;
            w_exc_tval = i_ls_addr;
        end else if (i_store_addr_misaligned) begin
            w_exc_code = TRAP_STORE_ADDR_MISALIGNED;
            w_exc_tval = i_ls_addr;
        end else begin
            w_exc = 1'b0;
        end
    end

    assign w_capture = (r_state == IDLE) & i_inst_valid & (w_irq_take | w_exc);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_capture)  w_state_next = PEND;
            PEND:    if (i_trap_ack) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_mcause <= '0;
            r_mtval  <= '0;
            r_mepc   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_mcause <= w_irq_take ? mk_mcause(1'b1, w_irq_code) : mk_mcause(1'b0, w_exc_code);
                r_mtval  <= w_irq_take ? '0 : w_exc_tval;
                r_mepc   <= i_pc;
            end
        end
    end

    assign o_mip        = w_mip;
    assign o_trap_valid = (r_state == PEND);
    assign o_stall      = (r_state == PEND);
    assign o_mcause     = r_mcause;
    assign o_mtval      = r_mtval;
    assign o_mepc       = r_mepc;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Registered, parametrised successor to the combinational trap dispatcher.
- Merges synchronous exceptions from the execute stage with asynchronous machine-level interrupts (software, timer, external, and N platform lines) into one prioritised trap request.
- Holds the request in a one-entry buffer until the CSR unit acknowledges it.
- Sits between execute/LSU and the CSR file; stalls the front end while a trap is pending.

Parameters:
- N_PLAT_IRQ, 4, number of platform interrupt lines; causes 16..16+N_PLAT_IRQ-1; legal range 0..16.
- IRQ_SYNC_STAGES, 2, synchroniser flop depth on every interrupt input; legal range ≥2.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_inst_valid  in  1  execute-stage instruction valid this cycle (instruction boundary)
- i_pc  in  XLEN  PC of execute-stage instruction
- i_inst  in  XLEN  instruction word
- i_ls_addr  in  XLEN  load/store effective address
- i_illegal_inst, i_inst_addr_misaligned, i_ecall_m, i_ebreak, i_load_addr_misaligned, i_store_addr_misaligned  in  1 each  exception flags, qualified by i_inst_valid
- i_irq_msi, i_irq_mti, i_irq_mei  in  1 each  asynchronous level interrupts
- i_irq_plat  in  N_PLAT_IRQ  asynchronous level platform interrupts
- i_mstatus_mie  in  1  global interrupt enable
- i_mie  in  MXLEN  per-cause interrupt enable (mie CSR)
- o_mip  out  MXLEN  synchronised pending vector for mip reads
- o_trap_valid  out  1  trap request held to CSR unit
- i_trap_ack  in  1  CSR unit has written mepc/mcause/mtval
- o_mcause  out  MXLEN  full mcause value (bit MXLEN-1 = interrupt)
- o_mtval  out  MXLEN  trap value
- o_mepc  out  XLEN  PC to save
- o_stall  out  1  front-end stall / flush request

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_trap_valid=0, o_stall=0, o_mcause/o_mtval/o_mepc=0, all synchroniser flops 0, o_mip=0.
- Reset asserted mid-PEND discards the trap; no ack expected afterwards.
- Synchroniser: each interrupt line passes IRQ_SYNC_STAGES flops.
- o_mip mapping: bit3=MSI, bit7=MTI, bit11=MEI, bit 16+i=plat[i]; all other bits 0.
- irq_take = i_mstatus_mie & |(o_mip & i_mie).
- Interrupt priority: MEI(11) > MSI(3) > MTI(7) > plat[0] > … > plat[N-1].
- Exception priority (fixed, unchanged): illegal > inst misaligned > ecall_m > ebreak > load misaligned > store misaligned.
- Event selection in IDLE with i_inst_valid=1: an interrupt beats any exception of the same instruction. The instruction is not retired and mepc = i_pc.
- With i_inst_valid=0, nothing is sampled, interrupts included.
- Capture on a selected event: next edge latches o_mcause, o_mtval, o_mepc=i_pc, sets o_trap_valid=1 and o_stall=1, and moves to PEND. Latency 1 cycle, event to o_trap_valid.
- mtval values:
  - illegal: i_inst
  - inst misaligned: i_pc
  - load/store misaligned: i_ls_addr
  - ecall, ebreak, interrupt: 0
- mcause values:
  - exceptions: {0, trap_cause_t code}
  - interrupts: {1, cause index}
- FSM is IDLE → PEND on capture; PEND → IDLE on i_trap_ack.
  - In PEND, all outputs hold stable and every new exception or interrupt is ignored; interrupts stay visible in o_mip and are re-evaluated after return.
  - The ack cycle is still PEND; o_trap_valid and o_stall drop on the following edge. The earliest next capture is the cycle after return to IDLE.
- i_trap_ack while IDLE is ignored.
- An interrupt deasserting after capture does not cancel the PEND trap.
- N_PLAT_IRQ=0: i_irq_plat port width handled via max(1,N) with the input ignored; mip bits 16+ are 0.

Decomposition:
- cotm32_priv_pkg gains:
  - irq_cause_t (IRQ_M_SOFT=3, IRQ_M_TIMER=7, IRQ_M_EXT=11, IRQ_PLAT_BASE=16)
  - trap_state_t {IDLE, PEND}
  - function mk_mcause(is_irq, code) returning MXLEN bits
- trap_cause_t is reused unchanged.
- One sub-module: trap_irq_sync (parametrised-depth, reset-to-0 synchroniser, width = 3+N_PLAT_IRQ), instantiated once.
- Priority selection stays inline as always_comb.

Test Plan:
- Reset, then drive i_illegal_inst=1, i_inst=0xFFFF_FFFF, i_pc=0x100, valid=1 → next cycle o_trap_valid=1, mcause=0x2, mtval=0xFFFF_FFFF, mepc=0x100; outputs hold until ack; IDLE one cycle after ack.
- i_load_addr_misaligned with i_store_addr_misaligned and ecall_m all high, ls_addr=0x2003 → mcause=0xB (ecall_m), mtval=0. With only load+store high → mcause=0x4, mtval=0x2003.
- mie=0x888, mstatus_mie=1, assert MTI and MEI asynchronously; valid=1 → o_trap_valid exactly IRQ_SYNC_STAGES+1 cycles after assertion, mcause=0x8000_000B, mepc=i_pc.
- Same interrupt with mstatus_mie=0, plus i_ebreak=1 → mcause=0x3, mip shows 0x880; then set mstatus_mie=1 → after ack, next trap mcause=0x8000_000B.
- In PEND, pulse i_illegal_inst and raise plat[2] with mie bit18=1 → no change to held outputs; after ack, plat[2] trap mcause=0x8000_0012.
- Drop i_rst_n mid-PEND → o_trap_valid and o_stall go 0 immediately (async); after release, no stale trap and mip=0 for IRQ_SYNC_STAGES cycles.
